mem_req_arbiter: RTL and testbench

Request arbiter and refresh scheduler in front of the SDRAM memory controller. It takes read/write requests from two requesters (port 0: AHB-Lite slave path, port 1: cache write-back path) and paces periodic auto-refresh. It presents one command at a time on the controller's `target_ba`/`target_addr`/`w_en`/`r_en`/`ref_en` inputs, handshaking on the controller's `BUSYn`.

---
 rtl/mem_req_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Arbitrates between two requesters and a periodic auto-refresh, and presents
//   one command at a time to the SDRAM controller.
//
//   Ports:
//     hclk, nrst                  clock, synchronous active-low reset
//     req_i/we_i                  per-port request level and direction (1 = write)
//     ba0_i/addr0_i, ba1_i/addr1_i per-port bank and address
//     gnt_o, done_o               one-cycle per-port grant / completion pulses
//     BUSYn                       controller ready (1 = idle/ready)
//     target_ba, target_addr      registered command address to the controller
//     w_en, r_en, ref_en          command strobes, mutually exclusive
//     ref_pending, ref_overrun    outstanding refresh credits, sticky credit loss
//     cmd_err                     one-cycle pulse when ISSUE times out
//     state_o                     FSM state (0 IDLE, 1 ISSUE, 2 WAIT_DONE)
//
//   Handshake: a command strobe is raised on entry to ISSUE and held until the
//   controller acknowledges by pulling BUSYn low; the command is complete when
//   BUSYn returns high. A requester holds req_i and its address stable until it
//   sees gnt_o, and may change them from the following cycle.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned BA_W         = 2,
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned REF_URGENT   = 2,
  parameter int unsigned CMD_TIMEOUT  = 16
) (
  input  logic              hclk,
  input  logic              nrst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [BA_W-1:0]   ba0_i,
  input  logic [BA_W-1:0]   ba1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  input  logic              BUSYn,
  output logic [BA_W-1:0]   target_ba,
  output logic [ADDR_W-1:0] target_addr,
  output logic              w_en,
  output logic              r_en,
  output logic              ref_en,
  output logic [2:0]        ref_pending,
  output logic              ref_overrun,
  output logic              cmd_err,
  output logic [1:0]        state_o
);

  localparam int unsigned REF_CW = $clog2(REF_INTERVAL + 1);
  localparam int unsigned TMO_W  = $clog2(CMD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [REF_CW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [2:0]          pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                last_q, last_d;     // port granted most recently
  logic                is_ref_q, is_ref_d; // current command is a refresh
  logic                port_q, port_d;     // client port of current command
  logic [BA_W-1:0]     ba_q, ba_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                w_en_q, w_en_d, r_en_q, r_en_d, ref_en_q, ref_en_d;
  logic [1:0]          gnt_q, gnt_d, done_q, done_d;
  logic                err_q, err_d;

  logic                wrap, urgent, grant_ref, restore, pick;
  logic [3:0]          pend_sum;

  assign wrap   = (ref_cnt_q == REF_CW'(REF_INTERVAL - 1));
  assign urgent = (32'(pend_q) >= REF_URGENT);
  // With both ports requesting, the port not granted last time wins.
  assign pick   = (req_i == 2'b11) ? ~last_q : req_i[1];

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    last_d    = last_q;
    is_ref_d  = is_ref_q;
    port_d    = port_q;
    ba_d      = ba_q;
    addr_d    = addr_q;
    w_en_d    = 1'b0;
    r_en_d    = 1'b0;
    ref_en_d  = 1'b0;
    gnt_d     = 2'b00;
    done_d    = 2'b00;
    err_d     = 1'b0;
    grant_ref = 1'b0;
    restore   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (BUSYn) begin
          if (urgent || (req_i == 2'b00 && pend_q != 3'd0)) begin
            grant_ref = 1'b1;
            state_d   = ST_ISSUE;
            tmo_d     = '0;
            is_ref_d  = 1'b1;
            ref_en_d  = 1'b1;
          end else if (req_i != 2'b00) begin
            state_d  = ST_ISSUE;
            tmo_d    = '0;
            is_ref_d = 1'b0;
            port_d   = pick;
            last_d   = pick;
            gnt_d    = pick ? 2'b10 : 2'b01;
            ba_d     = pick ? ba1_i : ba0_i;
            addr_d   = pick ? addr1_i : addr0_i;
            w_en_d   = we_i[pick];
            r_en_d   = ~we_i[pick];
          end
        end
      end
      ST_ISSUE: begin
        if (!BUSYn) begin
          state_d = ST_WAIT;
        end else if (tmo_q == TMO_W'(CMD_TIMEOUT - 1)) begin
          // Abandon the command; a refresh gets its credit back.
          state_d = ST_IDLE;
          err_d   = 1'b1;
          restore = is_ref_q;
        end else begin
          tmo_d    = tmo_q + TMO_W'(1);
          w_en_d   = w_en_q;
          r_en_d   = r_en_q;
          ref_en_d = ref_en_q;
        end
      end
      ST_WAIT: begin
        if (BUSYn) begin
          state_d = ST_IDLE;
          if (!is_ref_q) done_d = port_q ? 2'b10 : 2'b01;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Credit accounting; a grant only happens when a credit exists, so the
  // subtraction cannot underflow. Anything above 7 is a lost credit.
  always_comb begin
    ref_cnt_d = wrap ? '0 : ref_cnt_q + REF_CW'(1);
    pend_sum  = {1'b0, pend_q} + {3'b0, wrap} + {3'b0, restore} - {3'b0, grant_ref};
    ovr_d     = ovr_q;
    if (pend_sum > 4'd7) begin
      pend_d = 3'd7;
      ovr_d  = 1'b1;
    end else begin
      pend_d = pend_sum[2:0];
    end
  end

  always_ff @(posedge hclk) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      ref_cnt_q <= '0;
      pend_q    <= 3'd0;
      ovr_q     <= 1'b0;
      last_q    <= 1'b1;
      is_ref_q  <= 1'b0;
      port_q    <= 1'b0;
      ba_q      <= '0;
      addr_q    <= '0;
      w_en_q    <= 1'b0;
      r_en_q    <= 1'b0;
      ref_en_q  <= 1'b0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      ref_cnt_q <= ref_cnt_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      last_q    <= last_d;
      is_ref_q  <= is_ref_d;
      port_q    <= port_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      w_en_q    <= w_en_d;
      r_en_q    <= r_en_d;
      ref_en_q  <= ref_en_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign target_ba   = ba_q;
  assign target_addr = addr_q;
  assign w_en        = w_en_q;
  assign r_en        = r_en_q;
  assign ref_en      = ref_en_q;
  assign ref_pending = pend_q;
  assign ref_overrun = ovr_q;
  assign cmd_err     = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter
//   Bench for mem_req_arbiter. The bench plays both requesters and the SDRAM
//   controller; a transaction-level model predicts grants, strobes, pulses,
//   targets and refresh credits, and every output is compared every cycle.
module tb_mem_req_arbiter;
  localparam int ADDR_W       = 12;
  localparam int BA_W         = 2;
  localparam int REF_INTERVAL = 64;
  localparam int REF_URGENT   = 2;
  localparam int CMD_TIMEOUT  = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic              hclk = 1'b0;
  logic              nrst;
  logic [1:0]        req_i, we_i;
  logic [BA_W-1:0]   ba0_i, ba1_i;
  logic [ADDR_W-1:0] addr0_i, addr1_i;
  logic [1:0]        gnt_o, done_o;
  logic              BUSYn;
  logic [BA_W-1:0]   target_ba;
  logic [ADDR_W-1:0] target_addr;
  logic              w_en, r_en, ref_en;
  logic [2:0]        ref_pending;
  logic              ref_overrun, cmd_err;
  logic [1:0]        state_o;

  always #5 hclk = ~hclk;

  mem_req_arbiter #(
    .ADDR_W(ADDR_W), .BA_W(BA_W), .REF_INTERVAL(REF_INTERVAL),
    .REF_URGENT(REF_URGENT), .CMD_TIMEOUT(CMD_TIMEOUT)
  ) dut (
    .hclk(hclk), .nrst(nrst), .req_i(req_i), .we_i(we_i),
    .ba0_i(ba0_i), .ba1_i(ba1_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
    .gnt_o(gnt_o), .done_o(done_o), .BUSYn(BUSYn),
    .target_ba(target_ba), .target_addr(target_addr),
    .w_en(w_en), .r_en(r_en), .ref_en(ref_en),
    .ref_pending(ref_pending), .ref_overrun(ref_overrun),
    .cmd_err(cmd_err), .state_o(state_o)
  );

  // ---------------- reference model state ----------------
  int                n_vec = 0;
  int                n_err = 0;
  int                m_edges, m_pend, m_last;
  bit                m_ovr;
  logic [BA_W-1:0]   m_tba;
  logic [ADDR_W-1:0] m_taddr;
  bit                ev_gref, ev_restore;
  bit                served[2];
  logic [1:0]        exp_q[$];   // expected gnt_o value of each granted command

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge; credits follow the rules: one credit every REF_INTERVAL
  // edges since reset, minus refresh grants, plus credits returned on timeout,
  // saturating at 7 with the overrun flag recording any loss.
  task automatic step();
    int s;
    @(posedge hclk);
    if (!nrst) begin
      m_edges = 0; m_pend = 0; m_ovr = 1'b0; m_last = 1;
      m_tba = '0; m_taddr = '0;
    end else begin
      m_edges++;
      s = m_pend + ((m_edges % REF_INTERVAL) == 0 ? 1 : 0) + int'(ev_restore) - int'(ev_gref);
      if (s > 7) begin
        s = 7;
        m_ovr = 1'b1;
      end
      m_pend = s;
    end
    ev_gref = 1'b0;
    ev_restore = 1'b0;
    #1;
  endtask

  task automatic check_outs(input logic [1:0] eg, input logic [1:0] ed, input logic ee,
                            input logic [2:0] es, input logic [1:0] est);
    chk("gnt_o", 32'(gnt_o), 32'(eg));
    chk("done_o", 32'(done_o), 32'(ed));
    chk("cmd_err", 32'(cmd_err), 32'(ee));
    chk("strobes_w_r_ref", 32'({w_en, r_en, ref_en}), 32'(es));
    chk("ref_pending", 32'(ref_pending), 32'(m_pend));
    chk("ref_overrun", 32'(ref_overrun), 32'(m_ovr));
    chk("target_ba", 32'(target_ba), 32'(m_tba));
    chk("target_addr", 32'(target_addr), 32'(m_taddr));
    chk("state", 32'(state_o), 32'(est));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic we, input logic [BA_W-1:0] ba,
                         input logic [ADDR_W-1:0] a);
    served[p] = 1'b0;
    req_i[p]  = 1'b1;
    we_i[p]   = we;
    if (p == 0) begin
      ba0_i = ba; addr0_i = a;
    end else begin
      ba1_i = ba; addr1_i = a;
    end
  endtask

  task automatic rand_reqs();
    for (int p = 0; p < 2; p++) begin
      if (served[p] || !req_i[p]) begin
        served[p] = 1'b0;
        if ($urandom_range(0, 1) == 1)
          set_req(p, 1'($urandom_range(0, 1)), BA_W'($urandom_range(0, 3)),
                  ADDR_W'($urandom_range(0, 4095)));
        else
          req_i[p] = 1'b0;
      end
    end
  endtask

  // Called in an IDLE cycle with inputs set up for the decision edge. The
  // controller keeps BUSYn high for d1 ISSUE cycles, then low for d2 WAIT_DONE
  // cycles. Returns in the cycle after completion (done/err/idle cycle).
  task automatic run_cmd(input int d1, input int d2, input bit rst_in_wait);
    int         win;
    bit         is_ref;
    logic [2:0] strb;
    logic [1:0] g, dn;
    win = -1;
    if (BUSYn) begin
      if (m_pend >= REF_URGENT) win = 2;
      else if (req_i != 2'b00) win = (req_i == 2'b11) ? 1 - m_last : (req_i[1] ? 1 : 0);
      else if (m_pend > 0) win = 2;
    end
    if (win < 0) begin
      step();
      check_outs(2'b00, 2'b00, 1'b0, 3'b000, S_IDLE);
      return;
    end
    is_ref = (win == 2);
    if (is_ref) begin
      ev_gref = 1'b1;
      strb = 3'b001;
      dn = 2'b00;
      exp_q.push_back(2'b00);
    end else begin
      m_last = win;
      served[win] = 1'b1;
      m_tba   = (win == 1) ? ba1_i : ba0_i;
      m_taddr = (win == 1) ? addr1_i : addr0_i;
      strb = we_i[win] ? 3'b100 : 3'b010;
      dn = (win == 1) ? 2'b10 : 2'b01;
      exp_q.push_back(dn);
    end
    step();
    g = exp_q.pop_front();
    check_outs(g, 2'b00, 1'b0, strb, S_ISSUE);
    for (int i = 1; i <= CMD_TIMEOUT; i++) begin
      if (i > 1) check_outs(2'b00, 2'b00, 1'b0, strb, S_ISSUE);
      BUSYn = (i <= d1);
      if (BUSYn && i == CMD_TIMEOUT) begin
        ev_restore = is_ref;
        step();
        check_outs(2'b00, 2'b00, 1'b1, 3'b000, S_IDLE);
        return;
      end
      step();
      if (!BUSYn) break;
    end
    for (int j = 1; j <= d2 + 1; j++) begin
      check_outs(2'b00, 2'b00, 1'b0, 3'b000, S_WAIT);
      if (rst_in_wait) begin
        nrst = 1'b0;
        step();
        check_outs(2'b00, 2'b00, 1'b0, 3'b000, S_IDLE);
        nrst = 1'b1;
        return;
      end
      BUSYn = (j > d2);
      step();
    end
    check_outs(2'b00, dn, 1'b0, 3'b000, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nrst = 1'b0; BUSYn = 1'b0; req_i = 2'b00; we_i = 2'b00;
    ba0_i = '0; ba1_i = '0; addr0_i = '0; addr1_i = '0;
    ev_gref = 1'b0; ev_restore = 1'b0;
    served[0] = 1'b0; served[1] = 1'b0;
    step();
    step();
    check_outs(2'b00, 2'b00, 1'b0, 3'b000, S_IDLE);
    nrst = 1'b1;

    // Controller still initialising: nothing may issue.
    set_req(0, 1'b1, 2'd1, 12'hA0F);
    repeat (100) run_cmd(0, 0, 1'b0);
    BUSYn = 1'b1;
    run_cmd(1, 3, 1'b0);

    // Read with controller ack two cycles after the strobe.
    req_i[1] = 1'b0;
    set_req(0, 1'b0, 2'd2, 12'hAC9);
    run_cmd(2, 9, 1'b0);

    // Both ports requesting continuously: grants alternate.
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 2; p++)
        if (served[p] || !req_i[p])
          set_req(p, 1'($urandom_range(0, 1)), BA_W'($urandom_range(0, 3)),
                  ADDR_W'($urandom_range(0, 4095)));
      run_cmd(1, 2, 1'b0);
    end

    // Urgent refresh pre-empts a waiting client.
    req_i = 2'b00;
    set_req(0, 1'b1, 2'd3, 12'h155);
    BUSYn = 1'b0;
    for (int k = 0; k < 3 * REF_INTERVAL && m_pend < REF_URGENT; k++) run_cmd(0, 0, 1'b0);
    BUSYn = 1'b1;
    repeat (4) run_cmd(0, 2, 1'b0);

    // No clients: each credit becomes one opportunistic refresh.
    req_i = 2'b00;
    BUSYn = 1'b1;
    repeat (2 * REF_INTERVAL) run_cmd(0, 1, 1'b0);

    // Controller never acknowledges a client command.
    set_req(1, 1'b1, 2'd0, 12'h3C3);
    run_cmd(30, 0, 1'b0);

    // Saturation: controller busy for more than 8 intervals.
    req_i = 2'b00;
    BUSYn = 1'b0;
    repeat (8 * REF_INTERVAL + 4) run_cmd(0, 0, 1'b0);
    BUSYn = 1'b1;
    run_cmd(40, 0, 1'b0);
    repeat (12) run_cmd(0, 1, 1'b0);

    // Reset while waiting for completion.
    set_req(0, 1'b0, 2'd1, 12'h0F0);
    BUSYn = 1'b1;
    run_cmd(0, 5, 1'b1);

    // Randomised traffic and controller timing.
    repeat (300) begin
      rand_reqs();
      BUSYn = ($urandom_range(0, 7) != 0);
      run_cmd(($urandom_range(0, 11) == 0) ? 20 : int'($urandom_range(0, 3)),
              int'($urandom_range(0, 5)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
